// File: rtl/vgafb_pkg.sv
// Shared definitions for the VGA framebuffer fetch engine: FSM state
// encoding and the burst / FIFO geometry the fetcher and the pixel FIFO agree on.
package vgafb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    DATA    = 2'd2
  } vgafb_state_t;

  localparam int VGAFB_BURST_WORDS    = 4;
  localparam int VGAFB_FIFO_HALFWORDS = 16;
  localparam int VGAFB_BURST_BYTES    = 32;

endpackage

// File: rtl/vgafb_fetch_level.sv
// Mirror of the downstream pixel FIFO fill level, in 16-bit halfwords.
// A delivered 64-bit beat adds four halfwords, each consumer pull removes one.
module vgafb_fetch_level
  import vgafb_pkg::*;
(
  input  logic       sys_clk,
  input  logic       vga_rst_n,
  input  logic       beat_stb,
  input  logic       half_pull,
  output logic [4:0] level
);

  logic [5:0] level_nxt;

  // Net change for this cycle; bit 5 set means the pull would underflow.
  always_comb begin
    level_nxt = {1'b0, level}
              + (beat_stb  ? 6'(VGAFB_BURST_WORDS) : 6'd0)
              - (half_pull ? 6'd1 : 6'd0);
  end

  // Level register; out-of-range results are clamped so one bad pull cannot corrupt later fetch decisions.
  always_ff @(posedge sys_clk) begin
    if (!vga_rst_n) begin
      level <= '0;
    end else if (level_nxt[5]) begin
      level <= '0;
    end else if (level_nxt > 6'(VGAFB_FIFO_HALFWORDS)) begin
      level <= 5'(VGAFB_FIFO_HALFWORDS);
    end else begin
      level <= level_nxt[4:0];
    end
  end

  level_no_underflow: assert property (@(posedge sys_clk) disable iff (!vga_rst_n)
    !level_nxt[5]);

  level_no_overflow: assert property (@(posedge sys_clk) disable iff (!vga_rst_n)
    level_nxt[5] || (level_nxt <= 6'(VGAFB_FIFO_HALFWORDS)));

endmodule

// File: rtl/vgafb_fetch.sv
// FML burst-read master feeding the 64-to-16 pixel FIFO of the VGA framebuffer.
// Walks the frame one 4x64-bit burst at a time and only requests a burst once
// the downstream FIFO is completely empty, so beats never need to stall.
// Optional: define VGAFB_FETCH_STATS_EN to add the pixel_want input and the
// saturating underruns counter.
//
// state   | meaning
// IDLE    | waiting for enable and an empty downstream FIFO
// REQUEST | fml_stb asserted with a stable fml_adr, waiting for fml_ack
// DATA    | capturing the four beats that follow the ack cycle
module vgafb_fetch
  import vgafb_pkg::*;
#(
  parameter int fml_depth   = 26,
  parameter int burst_words = 4
) (
  input  logic                 sys_clk,
  input  logic                 vga_rst_n,
  input  logic                 enable,
  input  logic [fml_depth-1:0] baseaddress,
  input  logic [17:0]          nbursts,
  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  input  logic                 fml_ack,
  input  logic [63:0]          fml_di,
  output logic                 pixel_stb,
  output logic [63:0]          pixel_data,
  input  logic                 pixel_next,
  output logic                 frame_done
`ifdef VGAFB_FETCH_STATS_EN
  ,
  input  logic                 pixel_want,
  output logic [15:0]          underruns
`endif
);

  vgafb_state_t         state;
  logic [1:0]           beat_cnt;
  logic [17:0]          burst_cnt;
  logic [fml_depth-1:0] current_base;
  logic [4:0]           level;

  logic [17:0]          nbursts_eff;
  logic [17:0]          burst_cnt_inc;
  logic [fml_depth-1:0] frame_base;
  logic [fml_depth-1:0] next_adr;

  vgafb_fetch_level u_level (
    .sys_clk   (sys_clk),
    .vga_rst_n (vga_rst_n),
    .beat_stb  (pixel_stb),
    .half_pull (pixel_next),
    .level     (level)
  );

  // Address of the next burst; a fresh frame takes baseaddress directly since current_base is only loaded on that same edge.
  always_comb begin
    nbursts_eff   = (nbursts == 18'd0) ? 18'd1 : nbursts;
    burst_cnt_inc = burst_cnt + 18'd1;
    frame_base    = (burst_cnt == 18'd0) ? baseaddress : current_base;
    next_adr      = (frame_base & ~fml_depth'(VGAFB_BURST_BYTES - 1))
                  + fml_depth'(burst_cnt) * fml_depth'(VGAFB_BURST_BYTES);
  end

  // Fetch sequencer with registered FML and pixel outputs.
  always_ff @(posedge sys_clk) begin
    if (!vga_rst_n) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      burst_cnt    <= '0;
      current_base <= '0;
      fml_adr      <= '0;
      fml_stb      <= 1'b0;
      pixel_stb    <= 1'b0;
      pixel_data   <= '0;
      frame_done   <= 1'b0;
    end else begin
      pixel_stb  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (level == 5'd0)) begin
            state   <= REQUEST;
            fml_stb <= 1'b1;
            fml_adr <= next_adr;
            if (burst_cnt == 18'd0) begin
              current_base <= baseaddress;
            end
          end
        end
        REQUEST: begin
          if (fml_ack) begin
            fml_stb  <= 1'b0;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          pixel_data <= fml_di;
          pixel_stb  <= 1'b1;
          beat_cnt   <= beat_cnt + 2'd1;
          if (beat_cnt == 2'(burst_words - 1)) begin
            state <= IDLE;
            // >= so a shrunken nbursts wraps right after the burst in flight.
            if (burst_cnt_inc >= nbursts_eff) begin
              burst_cnt  <= '0;
              frame_done <= 1'b1;
            end else begin
              burst_cnt <= burst_cnt_inc;
            end
          end
        end
        default: begin
          state   <= IDLE;
          fml_stb <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGAFB_FETCH_STATS_EN
  // Count cycles where the consumer wanted pixels but the FIFO was empty.
  always_ff @(posedge sys_clk) begin
    if (!vga_rst_n) begin
      underruns <= '0;
    end else if (pixel_want && (level == 5'd0) && (underruns != 16'hFFFF)) begin
      underruns <= underruns + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vgafb_fetch.sv
// Randomized bench for vgafb_fetch: an FML slave with random ack latency and
// random beat data, a random consumer, and a frame-level reference model of
// burst addresses, beat delivery, frame wrap and FIFO fill.
module tb_vgafb_fetch;

  localparam int FD     = 26;
  localparam int NCYC   = 20000;

  logic          sys_clk = 1'b0;
  logic          vga_rst_n;
  logic          enable;
  logic [FD-1:0] baseaddress;
  logic [17:0]   nbursts;
  logic [FD-1:0] fml_adr;
  logic          fml_stb;
  logic          fml_ack;
  logic [63:0]   fml_di;
  logic          pixel_stb;
  logic [63:0]   pixel_data;
  logic          pixel_next;
  logic          frame_done;
`ifdef VGAFB_FETCH_STATS_EN
  logic          pixel_want;
  logic [15:0]   underruns;
`endif

  always #5 sys_clk = ~sys_clk;

  vgafb_fetch #(.fml_depth(FD), .burst_words(4)) dut (
    .sys_clk     (sys_clk),
    .vga_rst_n   (vga_rst_n),
    .enable      (enable),
    .baseaddress (baseaddress),
    .nbursts     (nbursts),
    .fml_adr     (fml_adr),
    .fml_stb     (fml_stb),
    .fml_ack     (fml_ack),
    .fml_di      (fml_di),
    .pixel_stb   (pixel_stb),
    .pixel_data  (pixel_data),
    .pixel_next  (pixel_next),
    .frame_done  (frame_done)
`ifdef VGAFB_FETCH_STATS_EN
    ,
    .pixel_want  (pixel_want),
    .underruns   (underruns)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int            lvl;          // halfwords in downstream FIFO this cycle
  bit            stb_q;        // pixel_stb seen last cycle
  bit            next_q;       // pixel_next driven last cycle
  bit            rst_q;        // reset driven last cycle
  bit            exp_pstb, exp_fdone, exp_fstb, exp_req;
  bit            in_req, busy;
  int            ack_delay, beats_left;
  int            k;            // burst index within the frame
  int            nb_eff;
  int            n_req, n_frames;
  int            drain_pct;
  int            u_model;
  logic [FD-1:0] frame_base, req_adr;
  logic [63:0]   beat, exp_data;
  logic [63:0]   beat_q[$];

  initial begin
    vga_rst_n   = 1'b0;
    enable      = 1'b1;
    baseaddress = FD'(32'h0010_0000);
    nbursts     = 18'd2;
    fml_ack     = 1'b0;
    fml_di      = '0;
    pixel_next  = 1'b0;
`ifdef VGAFB_FETCH_STATS_EN
    pixel_want  = 1'b0;
`endif
    lvl = 0; stb_q = 0; next_q = 0; rst_q = 1;
    exp_pstb = 0; exp_fdone = 0; exp_fstb = 0; exp_req = 0;
    in_req = 0; busy = 0; ack_delay = 0; beats_left = 0;
    k = 0; n_req = 0; n_frames = 0; drain_pct = 70; u_model = 0;
    frame_base = '0; req_adr = '0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge sys_clk);

      // ---- observe the cycle that just started ----
      if (rst_q) lvl = 0;
      else       lvl = lvl + (stb_q ? 4 : 0) - (next_q ? 1 : 0);

      if (rst_q) begin
        check_eq("rst_fml_stb",    fml_stb,    0);
        check_eq("rst_pixel_stb",  pixel_stb,  0);
        check_eq("rst_pixel_data", pixel_data, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_fml_adr",    fml_adr,    0);
        check_eq("rst_level",      dut.u_level.level, 0);
`ifdef VGAFB_FETCH_STATS_EN
        check_eq("rst_underruns",  underruns,  0);
`endif
        k = 0; beat_q.delete(); busy = 0; in_req = 0; beats_left = 0;
        u_model = 0; exp_pstb = 0; exp_fdone = 0;
      end else begin
        check_eq("fml_stb",    fml_stb,    exp_fstb);
        check_eq("pixel_stb",  pixel_stb,  exp_pstb);
        check_eq("frame_done", frame_done, exp_fdone);
        if (exp_pstb && beat_q.size() > 0) begin
          exp_data = beat_q.pop_front();
          if (pixel_stb) check_eq("pixel_data", pixel_data, exp_data);
        end
        if (fml_stb && !in_req && !busy) begin
          in_req = 1; busy = 1; n_req++;
          if (k == 0) frame_base = baseaddress;
          req_adr   = frame_base + FD'(k * 32);
          ack_delay = $urandom_range(0, 4);
          if ($urandom_range(0, 2) == 0) nbursts = 18'($urandom_range(0, 4));
          if (k != 0 && $urandom_range(0, 1) == 0)
            baseaddress = FD'($urandom) & ~FD'(31);
          if ($urandom_range(0, 3) == 0) enable = 1'b0;
        end
        if (fml_stb) check_eq("fml_adr", fml_adr, req_adr);
        check_eq("level", dut.u_level.level, 64'(lvl));
        check_eq("level_range", (lvl >= 0 && lvl <= 16), 1);
`ifdef VGAFB_FETCH_STATS_EN
        check_eq("underruns", underruns, 64'(u_model));
`endif
      end

      // ---- drive inputs for this cycle ----
      vga_rst_n = !((c < 3) || (c % 3000 == 1700) || (c % 3000 == 1701));

      if ($urandom_range(0, 199) == 0) drain_pct = $urandom_range(20, 100);
      if (enable == 1'b0) begin
        if ($urandom_range(0, 9) == 0) enable = 1'b1;
      end else if ($urandom_range(0, 79) == 0) begin
        enable = 1'b0;
      end

      fml_ack = 1'b0;
      fml_di  = {$urandom, $urandom};
      exp_pstb = 0; exp_fdone = 0;
      if (beats_left > 0) begin
        beat   = {$urandom, $urandom};
        fml_di = beat;
        beat_q.push_back(beat);
        exp_pstb = 1;
        beats_left--;
        if (beats_left == 0) begin
          nb_eff = (nbursts == 0) ? 1 : int'(nbursts);
          if (k + 1 >= nb_eff) begin
            k = 0; exp_fdone = 1; n_frames++;
          end else begin
            k++;
          end
          busy = 0;
        end
      end else if (in_req) begin
        if (ack_delay == 0) begin
          fml_ack = 1'b1; in_req = 0; beats_left = 4;
        end else begin
          ack_delay--;
        end
      end

      pixel_next = (lvl > 0) && ($urandom_range(1, 100) <= drain_pct);
`ifdef VGAFB_FETCH_STATS_EN
      pixel_want = ($urandom_range(0, 2) == 0);
      if (vga_rst_n && pixel_want && lvl == 0 && u_model < 65535) u_model++;
`endif

      exp_req  = vga_rst_n && enable && !busy && !in_req && (lvl == 0);
      exp_fstb = in_req || exp_req;
      stb_q    = pixel_stb;
      next_q   = pixel_next;
      rst_q    = !vga_rst_n;
    end

    check_eq("bursts_seen", (n_req > 100), 1);
    check_eq("frames_seen", (n_frames > 20), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vgafb_fetch.md
Name: vgafb_fetch

Overview:
- FML burst-read master feeding the 64-to-16 pixel FIFO of the VGA framebuffer.
- Walks the framebuffer from a base address, one 4×64-bit burst at a time, wrapping at end of frame.
- Strobes each 64-bit beat downstream.
- Mirrors downstream fill level from the consumer's pull pulses so it never overruns the 16-halfword FIFO.

Parameters:
- fml_depth, 26, FML byte-address width.
- burst_words, 4, 64-bit beats per FML burst; fixed at 4, must match FIFO depth.

Ports:
- sys_clk  in  1  system clock; only clock.
- vga_rst_n  in  1  synchronous, active-low reset, sampled on sys_clk rising edge.
- enable  in  1  fetch enable; low = finish current burst, then idle.
- baseaddress  in  fml_depth  frame start byte address, 32-byte aligned; latched at frame start.
- nbursts  in  18  bursts per frame; 0 treated as 1.
- fml_adr  out  fml_depth  burst address, low 5 bits always 0.
- fml_stb  out  1  burst request, held until ack.
- fml_ack  in  1  burst accepted.
- fml_di  in  64  read data, valid on the 4 cycles after the ack cycle.
- pixel_stb  out  1  one-cycle strobe per delivered 64-bit beat.
- pixel_data  out  64  beat data, valid with pixel_stb.
- pixel_next  in  1  downstream consumed one 16-bit word.
- frame_done  out  1  one-cycle pulse when the last beat of a frame is delivered.

Behaviour:
- Reset values: fml_stb=0, pixel_stb=0, pixel_data=0, frame_done=0, fml_adr=0. Internals: state=IDLE, level=0, burst_cnt=0, beat_cnt=0.
- level: 5-bit mirror of downstream halfwords, range 0..16.
  - Each cycle: +4 if pixel_stb, −1 if pixel_next; both in the same cycle gives net +3.
  - Must never exceed 16 or underflow; bench asserts this.
- IDLE → REQUEST when enable=1 and level==0 (all four FIFO slots free).
  - On the IDLE→REQUEST transition, fml_adr = current_base + burst_cnt×32.
  - current_base latches baseaddress when burst_cnt==0.
- REQUEST: fml_stb=1, fml_adr stable. On fml_ack: fml_stb drops the next cycle, beat_cnt=0, go to DATA.
- DATA: for 4 consecutive cycles, register fml_di to pixel_data and pulse pixel_stb one cycle later.
  - Latency from fml_di to pixel_stb is exactly 1 cycle.
  - Beats are never stalled; downstream always has room by construction.
- After beat 3 is captured:
  - burst_cnt+1; if it equals max(nbursts,1), burst_cnt=0 and frame_done pulses together with the 4th pixel_stb.
  - Return to IDLE.
- enable low mid-burst: REQUEST and DATA run to completion (FML cannot be aborted), then IDLE. burst_cnt is kept, so re-enable resumes the same frame.
- baseaddress change: takes effect only at the next frame start (burst_cnt==0).
- nbursts reduced below burst_cnt: the wrap compare uses ≥, so the frame wraps after the current burst.
- Reset mid-burst: all state cleared immediately. Late fml_di data is ignored because state is IDLE.

Optional Feature:
- Macro VGAFB_FETCH_STATS_EN.
- Defined: adds output underruns (16 bits) and input pixel_want (1 bit).
  - underruns increments, saturating at 0xFFFF, on each cycle with pixel_want=1 and level==0.
  - Cleared by reset.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package vgafb_pkg:
  - state encoding (IDLE=0, REQUEST=1, DATA=2);
  - VGAFB_BURST_WORDS=4;
  - VGAFB_FIFO_HALFWORDS=16;
  - VGAFB_BURST_BYTES=32.
- One natural sub-module: vgafb_fetch_level, the level-mirror counter with overflow and underflow assertions.

Test Plan:
- Reset, enable=1, base=0x100000, nbursts=2, no pixel_next:
  - fml_stb=1 with fml_adr=0x100000;
  - ack → 4 pixel_stb one cycle after each fml_di beat;
  - no second request while level=16.
- Drain 16 pixel_next:
  - level reaches 0, then 2nd request at 0x100020;
  - its last beat pulses frame_done;
  - 3rd request wraps to 0x100000.
- pixel_next coincident with pixel_stb: level goes 15 → 18 is illegal, so stimulus keeps level=0 at request. Check net +3 arithmetic: level 1 with both strobes → 4.
- Drop enable during REQUEST: burst completes with 4 beats, then no new fml_stb. Re-enable: next address continues at burst_cnt, not base.
- Change baseaddress to 0x200000 mid-frame: remaining bursts use old base; first burst after frame_done is 0x200000.
- VGAFB_FETCH_STATS_EN: pixel_want=1 for 10 cycles with level=0 → underruns=10. Reset mid-burst → underruns=0, fml_stb=0, and the next request is at base.
